// File: rtl/board_ram_if.sv
// Lock channel between the falling-piece logic and the playfield store,
// including the post-lock line-clear status it reports back.
interface board_ram_if;
  logic        lock_valid;
  logic        lock_ready;
  logic [35:0] lock_cells;
  logic [23:0] lock_color;
  logic        busy;
  logic        clear_done;
  logic [2:0]  lines;

  modport master (
    output lock_valid, lock_cells, lock_color,
    input  lock_ready, busy, clear_done, lines
  );

  modport slave (
    input  lock_valid, lock_cells, lock_color,
    output lock_ready, busy, clear_done, lines
  );
endinterface

// File: rtl/board_ram.sv
// Playfield of locked tetromino cells: pixel colour lookup, collision probes,
// four-cell lock writes and a scan/shift engine that removes full lines.
module board_ram #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int CELL = 20,
  parameter int X0   = 220,
  parameter int Y0   = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        row,
  input  logic [9:0]        column,
  output logic [23:0]       ram_color,
  input  logic [35:0]       probe_cells,
  output logic [3:0]        probe_hit,
  input  logic              clear_all,
  output logic              top_full,
  board_ram_if.slave        lock_bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

  logic [23:0] cells [ROWS][COLS];
  state_t      state;
  logic [4:0]  scan_r;
  logic [4:0]  shift_k;
  logic [2:0]  cnt;
  logic [2:0]  lines_q;
  logic        done_q;
  logic        busy_q;
  logic        ready_q;

  logic [4:0]  pix_r;
  logic [3:0]  pix_c;
  logic        in_board;
  logic        scan_full;

  function automatic logic addr_ok(input logic [8:0] a);
    return (int'(a[8:4]) < ROWS) && (int'(a[3:0]) < COLS);
  endfunction

  // Cell index from pixel position by threshold compare, avoiding a divider.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pix_r = '0;
    pix_c = '0;
    for (int i = 1; i < ROWS; i++)
      if (int'(row) >= Y0 + i * CELL) pix_r = 5'(i);
    for (int i = 1; i < COLS; i++)
      if (int'(column) >= X0 + i * CELL) pix_c = 4'(i);
  end

  assign in_board = (int'(column) >= X0) && (int'(column) < X0 + COLS * CELL) &&
                    (int'(row) >= Y0) && (int'(row) < Y0 + ROWS * CELL);
  assign ram_color = in_board ? cells[pix_r][pix_c] : '0;

  always_comb begin
    probe_hit = '0;
    for (int i = 0; i < 4; i++)
      probe_hit[i] = addr_ok(probe_cells[9*i +: 9]) ?
                     (cells[probe_cells[9*i+4 +: 5]][probe_cells[9*i +: 4]] != '0) : 1'b1;
  end

  always_comb begin
    scan_full = 1'b1;
    top_full  = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (cells[scan_r][c] == '0) scan_full = 1'b0;
      if (cells[0][c] != '0)      top_full  = 1'b1;
    end
  end

  // NOTE: the cell array is a flop bank, not a RAM macro, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) cells[r][c] <= '0;
      state   <= S_IDLE;
      scan_r  <= '0;
      shift_k <= '0;
      cnt     <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (clear_all) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) cells[r][c] <= '0;
      state   <= S_IDLE;
      scan_r  <= '0;
      shift_k <= '0;
      cnt     <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: if (lock_bus.lock_valid) begin
          // Out-of-range addresses are silently dropped; duplicates just rewrite.
          for (int i = 0; i < 4; i++)
            if (addr_ok(lock_bus.lock_cells[9*i +: 9]))
              cells[lock_bus.lock_cells[9*i+4 +: 5]][lock_bus.lock_cells[9*i +: 4]] <= lock_bus.lock_color;
          state   <= S_SCAN;
          scan_r  <= 5'(ROWS - 1);
          cnt     <= '0;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
        S_SCAN: begin
          if (scan_full) begin
            state   <= S_SHIFT;
            shift_k <= scan_r;
            if (cnt != 3'd4) cnt <= cnt + 3'd1;
          end else if (scan_r == '0) begin
            state   <= S_DONE;
            done_q  <= 1'b1;
            lines_q <= cnt;
          end else begin
            scan_r <= scan_r - 5'd1;
          end
        end
        S_SHIFT: begin
          // scan_r is left alone so the row that dropped into place is re-examined.
          if (shift_k != '0) begin
            for (int c = 0; c < COLS; c++) cells[shift_k][c] <= cells[shift_k - 5'd1][c];
            shift_k <= shift_k - 5'd1;
          end else begin
            for (int c = 0; c < COLS; c++) cells[0][c] <= '0;
            state <= S_SCAN;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lock_bus.lock_ready = ready_q;
  assign lock_bus.busy       = busy_q;
  assign lock_bus.clear_done = done_q;
  assign lock_bus.lines      = lines_q;

endmodule

// File: tb/tb_board_ram.sv
// Directed bench for board_ram: reset, pixel/probe mapping, lock passes,
// line clears, held lock during busy, clear_all abort and async reset.
module tb_board_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  row = '0;
  logic [9:0]  column = '0;
  logic [23:0] ram_color;
  logic [35:0] probe_cells = '0;
  logic [3:0]  probe_hit;
  logic        clear_all = 1'b0;
  logic        top_full;

  int checks = 0;
  int errors = 0;

  board_ram_if bus ();

  board_ram dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .column      (column),
    .ram_color   (ram_color),
    .probe_cells (probe_cells),
    .probe_hit   (probe_hit),
    .clear_all   (clear_all),
    .top_full    (top_full),
    .lock_bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] addr(input int r, input int c);
    return {r[4:0], c[3:0]};
  endfunction

  function automatic logic [35:0] quad(input logic [8:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    column = 10'(x);
    row    = 9'(y);
    #1;
    check(tag, 32'(ram_color), 32'(exp));
  endtask

  // Count non-empty cells by reading the centre pixel of each one.
  task automatic count_board(output int nz);
    nz = 0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) begin
        column = 10'(220 + c * 20 + 10);
        row    = 9'(40 + r * 20 + 10);
        #1;
        if (ram_color !== 24'h0) nz++;
      end
    @(negedge clk);
  endtask

  task automatic start_lock(input logic [35:0] c, input logic [23:0] color);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.lock_ready && n < 300) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(n < 300), 32'd1);
    bus.lock_valid = 1'b1;
    bus.lock_cells = c;
    bus.lock_color = color;
    tick();
    bus.lock_valid = 1'b0;
    check("busy_after_accept", 32'({bus.busy, bus.lock_ready}), 32'b10);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!bus.clear_done && n < 300) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic run_lock(input logic [35:0] c, input logic [23:0] color,
                          input int exp_n, input int exp_lines, input string tag);
    int n;
    start_lock(c, color);
    wait_done(n);
    check({tag, "_len"}, 32'(n), 32'(exp_n));
    check({tag, "_lines"}, 32'(bus.lines), 32'(exp_lines));
    tick();
    check({tag, "_idle"}, 32'({bus.busy, bus.lock_ready}), 32'b01);
  endtask

  initial begin
    int nz;
    int n;
    int early;
    int k;
    logic [35:0] q;

    bus.lock_valid = 1'b0;
    bus.lock_cells = '0;
    bus.lock_color = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.lock_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.clear_done), 32'd0);
    check("rst_lines", 32'(bus.lines), 32'd0);
    check("rst_top_full", 32'(top_full), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    nz = 0;
    for (int y = 0; y < 480; y += 3)
      for (int x = 0; x < 640; x += 5) begin
        column = 10'(x);
        row    = 9'(y);
        #1;
        if (ram_color !== 24'h0) nz++;
      end
    check("sweep_empty", 32'(nz), 32'd0);
    probe_cells = quad(addr(20, 0), addr(0, 10), addr(0, 0), addr(0, 0));
    #1;
    check("probe_range", 32'(probe_hit), 32'b0011);
    @(negedge clk);

    // Single lock, no clear
    run_lock(quad(addr(19, 0), addr(19, 1), addr(19, 2), addr(19, 3)), 24'h66B2FF, 21, 0, "single");
    pix("pix_220_420", 220, 420, 24'h66B2FF);
    pix("pix_299_439", 299, 439, 24'h66B2FF);
    pix("pix_300_420", 300, 420, 24'h0);
    pix("pix_219_420", 219, 420, 24'h0);
    pix("pix_220_440", 220, 440, 24'h0);
    probe_cells = quad(addr(19, 0), addr(19, 4), addr(19, 3), addr(18, 0));
    #1;
    check("probe_single", 32'(probe_hit), 32'b0101);

    // One-line clear
    run_lock(quad(addr(19, 4), addr(19, 5), addr(18, 0), addr(18, 0)), 24'h00FF00, 21, 0, "fill1");
    run_lock(quad(addr(19, 6), addr(19, 7), addr(19, 8), addr(19, 9)), 24'hFF0000, 42, 1, "clear1");
    pix("moved_cell", 230, 430, 24'h00FF00);
    pix("row18_empty", 230, 410, 24'h0);
    pix("row19_col1", 250, 430, 24'h0);
    probe_cells = quad(addr(18, 0), addr(19, 0), addr(19, 9), addr(0, 0));
    #1;
    check("probe_after_clear", 32'(probe_hit), 32'b0010);
    @(negedge clk);

    // clear_all from IDLE also zeroes lines
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check("clear_all_lines", 32'(bus.lines), 32'd0);
    count_board(nz);
    check("clear_all_board", 32'(nz), 32'd0);

    // Tetris: rows 16..19 full except col 9, then vertical I-piece
    for (int g = 0; g < 9; g++) begin
      q = '0;
      for (int j = 0; j < 4; j++) begin
        k = 4 * g + j;
        q[9*j +: 9] = addr(16 + k / 9, k % 9);
      end
      run_lock(q, 24'h123456, 21, 0, "tfill");
    end
    run_lock(quad(addr(16, 9), addr(17, 9), addr(18, 9), addr(19, 9)), 24'h00FFFF, 105, 4, "tetris");
    count_board(nz);
    check("tetris_board", 32'(nz), 32'd0);
    check("tetris_top_full", 32'(top_full), 32'd0);

    // top row, zero colour and out-of-range drop
    run_lock({4{addr(0, 0)}}, 24'h0000FF, 21, 0, "top");
    check("top_full_set", 32'(top_full), 32'd1);
    run_lock({4{addr(0, 0)}}, 24'h000000, 21, 0, "erase");
    check("top_full_erased", 32'(top_full), 32'd0);
    run_lock(quad(addr(20, 0), addr(0, 10), addr(31, 15), addr(1, 1)), 24'hABCDEF, 21, 0, "oor");
    count_board(nz);
    check("oor_count", 32'(nz), 32'd1);
    pix("oor_cell", 250, 70, 24'hABCDEF);

    // Lock held while busy: one write once ready returns
    start_lock(quad(addr(10, 0), addr(10, 1), addr(10, 2), addr(10, 3)), 24'hAAAAAA);
    probe_cells = {4{addr(5, 5)}};
    bus.lock_valid = 1'b1;
    bus.lock_cells = {4{addr(5, 5)}};
    bus.lock_color = 24'hBBBBBB;
    early = 0;
    n = 1;
    while (!bus.lock_ready && n < 300) begin
      if (probe_hit != 4'b0) early++;
      tick();
      n++;
    end
    check("held_no_early_write", 32'(early), 32'd0);
    check("held_ready_cycle", 32'(n), 32'd22);
    check("held_pre_accept", 32'(probe_hit), 32'b0000);
    tick();
    bus.lock_valid = 1'b0;
    check("held_written", 32'(probe_hit), 32'b1111);
    check("held_busy", 32'(bus.busy), 32'd1);
    wait_done(n);
    check("held_len", 32'(n), 32'd21);
    repeat (5) tick();
    check("held_single_pass", 32'({bus.busy, bus.lock_ready}), 32'b01);

    // clear_all in the middle of SHIFT
    run_lock(quad(addr(19, 0), addr(19, 1), addr(19, 2), addr(19, 3)), 24'h111111, 21, 0, "ca_a");
    run_lock(quad(addr(19, 4), addr(19, 5), addr(19, 6), addr(19, 7)), 24'h111111, 21, 0, "ca_b");
    start_lock(quad(addr(19, 8), addr(19, 9), addr(19, 8), addr(19, 9)), 24'h111111);
    repeat (4) tick();
    check("ca_busy_before", 32'(bus.busy), 32'd1);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check("ca_idle", 32'({bus.busy, bus.lock_ready}), 32'b01);
    check("ca_lines", 32'(bus.lines), 32'd0);
    early = 0;
    repeat (30) begin
      tick();
      if (bus.clear_done) early++;
    end
    check("ca_no_done", 32'(early), 32'd0);
    count_board(nz);
    check("ca_board", 32'(nz), 32'd0);

    // Async reset mid-pass
    run_lock(quad(addr(19, 0), addr(19, 1), addr(19, 2), addr(19, 3)), 24'h222222, 21, 0, "ar_a");
    run_lock(quad(addr(19, 4), addr(19, 5), addr(19, 6), addr(19, 7)), 24'h222222, 21, 0, "ar_b");
    run_lock(quad(addr(19, 8), addr(19, 9), addr(19, 8), addr(19, 9)), 24'h222222, 42, 1, "ar_c");
    probe_cells = {4{addr(0, 0)}};
    column = 10'd230;
    row    = 9'd50;
    start_lock({4{addr(0, 0)}}, 24'h777777);
    repeat (2) tick();
    check("ar_pre_color", 32'(ram_color), 32'h777777);
    check("ar_pre_top", 32'(top_full), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_ready", 32'(bus.lock_ready), 32'd1);
    check("ar_done", 32'(bus.clear_done), 32'd0);
    check("ar_lines", 32'(bus.lines), 32'd0);
    check("ar_color", 32'(ram_color), 32'd0);
    check("ar_probe", 32'(probe_hit), 32'd0);
    check("ar_top", 32'(top_full), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
